// File: rtl/case_map_reg.sv
// case_map_reg: registered key->value lookup table with priority match and miss counter
module case_map_reg #(
  parameter int KEY_W = 4,
  parameter int VAL_W = 1,
  parameter int DEPTH = 4,
  parameter int MISS_MODE = 0,
  parameter logic [VAL_W-1:0] DEFAULT_VAL = '0,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [KEY_W-1:0] cfg_key,
  input  logic [VAL_W-1:0] cfg_val,
  input  logic             cfg_en,
  input  logic             in_valid,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  output logic [VAL_W-1:0] out_val,
  output logic             out_hit,
  output logic [15:0]      miss_cnt
);
  logic [DEPTH-1:0]            en;
  logic [DEPTH-1:0][KEY_W-1:0] keys;
  logic [DEPTH-1:0][VAL_W-1:0] vals;
  logic                        hit;
  logic [VAL_W-1:0]            hit_val;
  logic [VAL_W-1:0]            miss_val;
  // scan from the top so the lowest matching index is the last to assign
  always_comb begin
    hit = 1'b0;
    hit_val = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (en[i] && keys[i] == in_key) begin
        hit = 1'b1;
        hit_val = vals[i];
      end
    end
    miss_val = (MISS_MODE == 1) ? DEFAULT_VAL : out_val;
  end
  // table writes land after the lookup sampled the old contents
  always_ff @(posedge clk) begin
    if (rst) begin
      en <= '0;
      keys <= '0;
      vals <= '0;
      out_valid <= 1'b0;
      out_val <= '0;
      out_hit <= 1'b0;
      miss_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cfg_we && cfg_idx == IDX_W'(i)) begin
          en[i] <= cfg_en;
          keys[i] <= cfg_key;
          vals[i] <= cfg_val;
        end
      end
      out_valid <= in_valid;
      if (in_valid) begin
        out_hit <= hit;
        out_val <= hit ? hit_val : miss_val;
        if (!hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_case_map_reg.sv
// tb_case_map_reg: random and directed checks of case_map_reg against a table model
module tb_case_map_reg;
  logic clk = 1'b0;
  logic rst, cfg_we, cfg_en, in_valid;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_key, in_key;
  logic cfg_val;
  logic v0, h0, o0, v1, h1, o1;
  logic [15:0] m0, m1;
  int checks = 0;
  int errors = 0;
  logic m_en [4];
  logic [3:0] m_key [4];
  logic m_val [4];
  logic e_valid, e_hit, e_v0, e_v1;
  logic [15:0] e_miss;

  always #5 clk = ~clk;

  case_map_reg dut0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
    .cfg_val(cfg_val), .cfg_en(cfg_en), .in_valid(in_valid), .in_key(in_key),
    .out_valid(v0), .out_val(o0), .out_hit(h0), .miss_cnt(m0)
  );

  case_map_reg #(.MISS_MODE(1), .DEFAULT_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
    .cfg_val(cfg_val), .cfg_en(cfg_en), .in_valid(in_valid), .in_key(in_key),
    .out_valid(v1), .out_val(o1), .out_hit(h1), .miss_cnt(m1)
  );

  wire [37:0] act = {v0, h0, o0, m0, v1, h1, o1, m1};

  function automatic logic [37:0] exp_vec();
    return {e_valid, e_hit, e_v0, e_miss, e_valid, e_hit, e_v1, e_miss};
  endfunction

  task automatic cycle(input logic r, input logic we, input logic [1:0] idx, input logic [3:0] k,
                       input logic v, input logic e, input logic iv, input logic [3:0] ik);
    logic found;
    logic fv;
    rst = r; cfg_we = we; cfg_idx = idx; cfg_key = k; cfg_val = v; cfg_en = e;
    in_valid = iv; in_key = ik;
    if (r) begin
      for (int i = 0; i < 4; i++) begin m_en[i] = 0; m_key[i] = 0; m_val[i] = 0; end
      e_valid = 0; e_hit = 0; e_v0 = 0; e_v1 = 0; e_miss = 0;
    end else begin
      if (iv) begin
        found = 0; fv = 0;
        for (int i = 0; i < 4; i++)
          if (!found && m_en[i] && m_key[i] == ik) begin found = 1; fv = m_val[i]; end
        e_hit = found;
        if (found) begin e_v0 = fv; e_v1 = fv; end
        else begin
          e_v1 = 0;
          if (e_miss != 16'hFFFF) e_miss = e_miss + 1;
        end
      end
      e_valid = iv;
      if (we) begin m_en[idx] = e; m_key[idx] = k; m_val[idx] = v; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (act !== 38'd0) begin errors++; $display("FAIL reset: got %h want %h", act, 38'd0); end
  endtask

  task automatic test_basic();
    cycle(0, 1, 0, 4'h1, 1, 1, 0, 0);
    cycle(0, 1, 1, 4'h2, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 4'h1);
    checks++;
    if (act !== exp_vec() || !v0 || o0 !== 1'b1 || !h0) begin errors++; $display("FAIL basic_key1: got %h want %h", act, exp_vec()); end
    cycle(0, 0, 0, 0, 0, 0, 1, 4'h2);
    checks++;
    if (act !== exp_vec() || o0 !== 1'b0 || !h0) begin errors++; $display("FAIL basic_key2: got %h want %h", act, exp_vec()); end
    cycle(0, 0, 0, 0, 0, 0, 0, 4'h1);
    checks++;
    if (act !== exp_vec() || v0) begin errors++; $display("FAIL basic_idle_hold: got %h want %h", act, exp_vec()); end
  endtask

  task automatic test_miss();
    cycle(0, 0, 0, 0, 0, 0, 1, 4'h1);
    cycle(0, 0, 0, 0, 0, 0, 1, 4'h7);
    checks++;
    if (act !== exp_vec() || o0 !== 1'b1 || o1 !== 1'b0 || h0 || m0 !== 16'd1) begin errors++; $display("FAIL miss_hold_default: got %h want %h", act, exp_vec()); end
  endtask

  task automatic test_priority();
    cycle(0, 1, 1, 4'h5, 0, 1, 0, 0);
    cycle(0, 1, 3, 4'h5, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 4'h5);
    checks++;
    if (act !== exp_vec() || o0 !== 1'b0 || !h0) begin errors++; $display("FAIL priority_low: got %h want %h", act, exp_vec()); end
    cycle(0, 1, 1, 4'h5, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 4'h5);
    checks++;
    if (act !== exp_vec() || o0 !== 1'b1 || !h0) begin errors++; $display("FAIL priority_cleared: got %h want %h", act, exp_vec()); end
  endtask

  task automatic test_same_cycle();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 4'h9, 1, 1, 1, 4'h9);
    checks++;
    if (act !== exp_vec() || h0 || !v0) begin errors++; $display("FAIL same_cycle_miss: got %h want %h", act, exp_vec()); end
    cycle(0, 0, 0, 0, 0, 0, 1, 4'h9);
    checks++;
    if (act !== exp_vec() || !h0 || o0 !== 1'b1) begin errors++; $display("FAIL same_cycle_next_hit: got %h want %h", act, exp_vec()); end
  endtask

  task automatic test_random();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)));
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL random[%0d]: got %h want %h", n, act, exp_vec()); end
    end
  endtask

  task automatic test_saturation();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 2, 4'h3, 1, 1, 0, 0);
    for (int n = 0; n < 65534; n++) cycle(0, 0, 0, 0, 0, 0, 1, 4'h7);
    checks++;
    if (act !== exp_vec() || m0 !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h want %h", act, exp_vec()); end
    cycle(0, 0, 0, 0, 0, 0, 1, 4'h7);
    cycle(0, 0, 0, 0, 0, 0, 1, 4'h7);
    checks++;
    if (act !== exp_vec() || m0 !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h want %h", act, exp_vec()); end
    cycle(0, 0, 0, 0, 0, 0, 1, 4'h7);
    checks++;
    if (act !== exp_vec() || m1 !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want %h", act, exp_vec()); end
    cycle(1, 0, 0, 0, 0, 0, 1, 4'h3);
    checks++;
    if (act !== 38'd0) begin errors++; $display("FAIL reset_inflight: got %h want %h", act, 38'd0); end
    cycle(0, 0, 0, 0, 0, 0, 1, 4'h3);
    checks++;
    if (act !== exp_vec() || !v0 || h0 || m0 !== 16'd1) begin errors++; $display("FAIL post_reset_lookup: got %h want %h", act, exp_vec()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_miss();
    test_priority();
    test_same_cycle();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/case_map_reg.md
CASE_MAP_REG -- requirements
Module: case_map_reg

Interface
REQ-001 Parameter KEY_W, default 4, SHALL set the lookup key width in bits (legal range 1..16).
REQ-002 Parameter VAL_W, default 1, SHALL set the mapped value width in bits (legal range 1..32).
REQ-003 Parameter DEPTH, default 4, SHALL set the number of table entries (legal range 2..16); IDX_W = clog2(DEPTH).
REQ-004 Parameter MISS_MODE, default 0, SHALL select the miss behaviour: 0 = hold last output value, 1 = drive DEFAULT_VAL.
REQ-005 Parameter DEFAULT_VAL, default 0, SHALL set the VAL_W-bit value driven on a miss when MISS_MODE=1.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  SHALL be the reset; reset is synchronous and active-high.
REQ-008 cfg_we  input  1  SHALL be the table write strobe.
REQ-009 cfg_idx  input  IDX_W  SHALL select the entry written.
REQ-010 cfg_key  input  KEY_W  SHALL be the match key written.
REQ-011 cfg_val  input  VAL_W  SHALL be the mapped value written.
REQ-012 cfg_en  input  1  SHALL be the entry-valid bit written.
REQ-013 in_valid  input  1  SHALL qualify in_key.
REQ-014 in_key  input  KEY_W  SHALL be the key to look up.
REQ-015 out_valid  output  1  SHALL flag a completed lookup.
REQ-016 out_val  output  VAL_W  SHALL be the registered result.
REQ-017 out_hit  output  1  SHALL be 1 when the completed lookup matched an entry.
REQ-018 miss_cnt  output  16  SHALL count lookups that missed.

Function
REQ-019 Each entry SHALL hold {en, key, val} in registers; no storage other than flip-flops clocked by clk.
REQ-020 A cycle with cfg_we=1 SHALL write {cfg_en, cfg_key, cfg_val} into entry cfg_idx at the clock edge; cfg_idx >= DEPTH SHALL be ignored.
REQ-021 A lookup with in_valid=1 SHALL produce out_valid=1 exactly one cycle later; out_valid SHALL be 0 in every cycle following in_valid=0.
REQ-022 A hit SHALL occur when any entry has en=1 and key==in_key; on multiple matches the lowest index SHALL win.
REQ-023 On a hit, out_val SHALL be the winning entry's val and out_hit SHALL be 1.
REQ-024 On a miss, out_hit SHALL be 0; out_val SHALL retain its previous value if MISS_MODE=0, or take DEFAULT_VAL if MISS_MODE=1.
REQ-025 While in_valid=0, out_val and out_hit SHALL hold their values (explicit registered hold, never a latch).
REQ-026 A write and a lookup in the same cycle SHALL use the table contents before the write (write visible from the next cycle).
REQ-027 miss_cnt SHALL increment by 1 per missed lookup and saturate at 16'hFFFF without wrap.
REQ-028 The lookup decision logic SHALL assign every result signal on every path (full case coverage, default branch present); lint SHALL report no inferred latches.

Reset
REQ-029 While rst=1 at a clock edge, all entries SHALL clear to en=0, key=0, val=0; out_valid=0, out_val=0, out_hit=0, miss_cnt=0.
REQ-030 rst SHALL take priority over cfg_we and in_valid in the same cycle; a lookup in flight when rst asserts SHALL be discarded (out_valid=0 next cycle).
REQ-031 After rst deasserts, the first lookup SHALL be accepted in the first cycle with rst=0.

Verification
REQ-032 Defaults; write idx0 {1,4'h1,1}, idx1 {1,4'h2,0}; look up 4'h1 then 4'h2 -> out_valid pulses in the next cycles with out_val=1,hit=1 then out_val=0,hit=1.
REQ-033 MISS_MODE=0: after out_val=1, look up 4'h7 (no entry) -> out_val stays 1, out_hit=0, miss_cnt=1; MISS_MODE=1, DEFAULT_VAL=0 -> out_val=0.
REQ-034 Entries idx1 and idx3 both key 4'h5 with val 0 and 1 -> lookup 4'h5 returns out_val=0 (idx1 wins); clear idx1 en -> returns 1.
REQ-035 Same cycle: write idx0 {1,4'h9,1} and look up 4'h9 on empty table -> miss (hit=0); repeat lookup next cycle -> hit, out_val=1.
REQ-036 Force miss_cnt to 16'hFFFE via 2 extra misses -> reads 16'hFFFF and stays there; assert rst with in_valid=1 -> next cycle out_valid=0, miss_cnt=0, all entries invalid.
